array_select_arbiter: RTL

//  Shares one WIDTH-bit bit-select (array-select) stage among NREQ requesters.

---
 rtl/array_select_arbiter.sv | 98 +++++++++
 1 files changed

// File: rtl/array_select_arbiter.sv
// Purpose: round-robin shares one WIDTH-bit array-select stage (out[i] = in[sel[i]]) among NREQ requesters.
// Latency: one cycle from the accepting edge to the result on resp_*.
// Backpressure: a held result with resp_ready low blocks all grants; drain and refill on one edge keeps full throughput.
module array_select_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 2,
  parameter int SELW  = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                        CLK,
  input  logic                        ASYNCRESETN,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ*WIDTH-1:0]       req_data,
  input  logic [NREQ*WIDTH*SELW-1:0]  req_sel,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [WIDTH-1:0]            resp_data,
  output logic [IDW-1:0]              resp_id
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]       state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   rr_next;
  logic             can_accept;
  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;
  logic             grant;
  logic [WIDTH-1:0] gnt_word;
  logic [WIDTH-1:0] perm;
  logic [SELW-1:0]  sel_f;
  int               idx;
  int               base;

  assign resp_valid = (state == FULL);
  assign can_accept = (state == EMPTY) | (resp_valid & resp_ready);
  assign grant      = can_accept & gnt_found;

  // Pick the first valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int j = 0; j < NREQ; j++) begin
      idx = (int'(rr_ptr) + j) % NREQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(idx);
      end
    end
  end

  // Ready is forced low while reset is held, even though the FSM sits in EMPTY.
  always_comb begin
    req_ready = '0;
    if (grant && ASYNCRESETN) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  // Array-select of the granted word; out-of-range select fields read as 0.
  always_comb begin
    perm     = '0;
    sel_f    = '0;
    base     = int'(gnt_idx) * WIDTH;
    gnt_word = req_data[base +: WIDTH];
    for (int i = 0; i < WIDTH; i++) begin
      sel_f   = req_sel[(base + i) * SELW +: SELW];
      perm[i] = (int'(sel_f) < WIDTH) ? gnt_word[sel_f] : 1'b0;
    end
  end

  // Priority moves to the requester after the one just granted.
  always_comb begin
    rr_next = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
  end

  // Output register and FSM: load on grant, otherwise empty on drain; data/id hold on drain.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state     <= EMPTY;
      rr_ptr    <= '0;
      resp_data <= '0;
      resp_id   <= '0;
    end else if (grant) begin
      state     <= FULL;
      rr_ptr    <= rr_next;
      resp_data <= perm;
      resp_id   <= gnt_idx;
    end else if (resp_valid && resp_ready) begin
      state     <= EMPTY;
    end
  end

endmodule
